// File: rtl/barrett_pkg.sv
// Shared types and constants for the Barrett parameter generator and its
// leading-one detector.
package barrett_pkg;

    localparam int QW_DEF     = 64;
    localparam int MUW_DEF    = 31;
    localparam int KW_DEF     = 8;
    localparam int DIV_STEPS  = 59;
    localparam int Q_MAX_BITS = 29;
    localparam int REM_W      = Q_MAX_BITS + 2;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/barrett_msb_len.sv
// Combinational leading-one detector: returns the bit length of q
// (index of the highest set bit plus one, zero for q == 0).
module barrett_msb_len
    import barrett_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic [QW-1:0] q_i,
    output logic [KW-1:0] len_o
);

    always_comb begin
        len_o = '0;
        for (int unsigned i = 0; i < QW; i++) begin
            if (q_i[i]) begin
                len_o = KW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/barrett_param_gen.sv
// Computes k = bitlen(q) and mu = floor(2^(2k)/q) for a Barrett reducer,
// using a fixed-length restoring bit-serial divider.
module barrett_param_gen
    import barrett_pkg::*;
#(
    parameter int QW  = QW_DEF,
    parameter int MUW = MUW_DEF,
    parameter int KW  = KW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [QW-1:0]  q_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [QW-1:0]  q_out,
    output logic [KW-1:0]  k_out,
    output logic [MUW-1:0] mu_out,
    output logic           err
);

    state_e           state_q;
    logic [QW-1:0]    q_q;
    logic [KW-1:0]    k_q;
    logic [REM_W-1:0] rem_q;
    logic [MUW-1:0]   quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             out_valid_q;
    logic [QW-1:0]    q_out_q;
    logic [KW-1:0]    k_out_q;
    logic [MUW-1:0]   mu_out_q;
    logic             err_out_q;

    logic [KW-1:0]    len;
    logic             q_bad;
    logic [CNT_W-1:0] bit_pos;
    logic [KW:0]      two_k;
    logic             div_bit;
    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] q_ext;
    logic             rem_ge;
    logic [REM_W-1:0] rem_d;
    logic [MUW-1:0]   quo_d;

    barrett_msb_len #(
        .QW (QW),
        .KW (KW)
    ) u_msb_len (
        .q_i   (q_q),
        .len_o (len)
    );

    assign q_bad = (q_in == '0) || (q_in[QW-1:Q_MAX_BITS] != '0);

    // Dividend 2^(2k) is never stored: its single set bit is generated on the fly.
    assign bit_pos   = CNT_W'(DIV_STEPS - 1) - cnt_q;
    assign two_k     = {k_q, 1'b0};
    assign div_bit   = (32'(two_k) == 32'(bit_pos));
    assign rem_shift = {rem_q[REM_W-2:0], div_bit};
    assign q_ext     = {{(REM_W - Q_MAX_BITS){1'b0}}, q_q[Q_MAX_BITS-1:0]};
    assign rem_ge    = (rem_shift >= q_ext);

    always_comb begin
        rem_d = rem_shift;
        quo_d = {quo_q[MUW-2:0], rem_ge};
        if (rem_ge) begin
            rem_d = rem_shift - q_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            k_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            k_out_q     <= '0;
            mu_out_q    <= '0;
            err_out_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_q <= q_in;
                        if (q_bad) begin
                            err_q   <= 1'b1;
                            k_q     <= '0;
                            quo_q   <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    k_q     <= len;
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    quo_q   <= '0;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle loads the output registers; valid rises after it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        q_out_q     <= q_q;
                        k_out_q     <= k_q;
                        mu_out_q    <= quo_q;
                        err_out_q   <= err_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign q_out     = q_out_q;
    assign k_out     = k_out_q;
    assign mu_out    = mu_out_q;
    assign err       = err_out_q;

endmodule

// File: tb/tb_barrett_param_gen.sv
// Randomised self-checking bench for barrett_param_gen against an
// arithmetic reference of bitlen(q) and floor(2^(2k)/q).
module tb_barrett_param_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] q_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] q_out;
    logic [7:0]  k_out;
    logic [30:0] mu_out;
    logic        err;

    int n_vec;
    int n_err;

    barrett_param_gen #(
        .QW  (64),
        .MUW (31),
        .KW  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .k_out     (k_out),
        .mu_out    (mu_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [63:0] q, output logic [63:0] k,
                             output logic [63:0] mu, output logic e);
        logic [63:0] t;
        k  = 0;
        mu = 0;
        e  = (q == 0) || (q >= (64'd1 << 29));
        if (!e) begin
            t = q;
            while (t != 0) begin
                k++;
                t = t >> 1;
            end
            mu = (64'd1 << (2 * k)) / q;
        end
    endtask

    task automatic run_q(input logic [63:0] q, input int hold);
        logic [63:0] ek, emu;
        logic        eerr;
        int          lat;
        int          exp_lat;
        ref_model(q, ek, emu, eerr);
        exp_lat = eerr ? 1 : 61;
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        q_in     = q;
        @(posedge clk);
        #1;
        // Keep in_valid high with junk data: must be ignored while busy.
        q_in = {$urandom, $urandom};
        lat  = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, exp_lat);
        check_eq("q_out", q_out, q);
        check_eq("k_out", k_out, ek);
        check_eq("mu_out", mu_out, emu);
        check_eq("err", err, eerr);
        check_eq("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_ready", in_ready, 0);
            check_eq("hold_q", q_out, q);
            check_eq("hold_k", k_out, ek);
            check_eq("hold_mu", mu_out, emu);
            check_eq("hold_err", err, eerr);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("valid_drop", out_valid, 0);
        check_eq("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [63:0] q;
        int          k;
        logic        seen;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_q_out", q_out, 0);
        check_eq("rst_k_out", k_out, 0);
        check_eq("rst_mu_out", mu_out, 0);
        check_eq("rst_err", err, 0);

        run_q(64'd768112, 0);
        run_q(64'd1, 0);
        run_q((64'd1 << 29) - 1, 0);
        run_q(64'd0, 0);
        run_q(64'd1 << 29, 0);
        run_q(64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_q(64'd768112, 10);

        // Abort mid-division with a reset pulse at step 30.
        @(negedge clk);
        in_valid = 1'b1;
        q_in     = 64'd768112;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_q_out", q_out, 0);
        check_eq("abort_k_out", k_out, 0);
        check_eq("abort_mu_out", mu_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_result", seen, 0);
        run_q(64'd768112, 0);

        for (int n = 0; n < 1000; n++) begin
            k = $urandom_range(29, 1);
            q = (64'd1 << (k - 1)) | ({32'd0, $urandom} & ((64'd1 << (k - 1)) - 1));
            run_q(q, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
